// File: rtl/fight_pkg.sv
// fight_pkg: shared encodings and constants for the P1/P2 gameplay controllers
// and the hit resolver.
//  - player state codes (4-bit, shared with the controllers)
//  - stunmode codes driven to each controller
//  - winner codes and round FSM states
//  - geometry, damage and timing constants
//  - sat_sub: health subtraction that stops at zero
package fight_pkg;

    // Bus widths
    localparam int unsigned POS_W       = 10;
    localparam int unsigned GAP_W       = 11;
    localparam int unsigned STATE_W     = 4;
    localparam int unsigned HEALTH_W    = 4;
    localparam int unsigned STUN_W      = 2;
    localparam int unsigned WIN_W       = 2;
    localparam int unsigned FRAME_CNT_W = 6;

    // Geometry (pixels)
    localparam int unsigned PLAYER_WIDTH = 64;
    localparam int unsigned I_REACH      = 32;
    localparam int unsigned D_REACH      = 48;

    // Health and damage
    localparam int unsigned MAX_HEALTH  = 10;
    localparam int unsigned HIT_DAMAGE  = 2;
    localparam int unsigned CHIP_DAMAGE = 1;

    // Frames spent in READY before FIGHT
    localparam int unsigned READY_FRAMES = 60;

    // Controller state encoding
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE             = 4'd0,
        ST_FORWARD          = 4'd1,
        ST_BACKWARD         = 4'd2,
        ST_IATTACK_START    = 4'd3,
        ST_IATTACK_ACTIVE   = 4'd4,
        ST_IATTACK_RECOVERY = 4'd5,
        ST_DATTACK_START    = 4'd6,
        ST_DATTACK_ACTIVE   = 4'd7,
        ST_DATTACK_RECOVERY = 4'd8,
        ST_HITSTUN          = 4'd9,
        ST_BLOCKSTUN        = 4'd10
    } player_state_t;

    typedef enum logic [STUN_W-1:0] {
        STUN_NONE  = 2'b00,
        STUN_HIT   = 2'b01,
        STUN_BLOCK = 2'b10
    } stunmode_t;

    typedef enum logic [WIN_W-1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        RND_READY = 2'd0,
        RND_FIGHT = 2'd1,
        RND_KO    = 2'd2
    } round_state_t;

    // Health minus damage, clamped at zero
    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] health,
        input logic [HEALTH_W-1:0] damage
    );
        return (health > damage) ? (health - damage) : '0;
    endfunction

endpackage

// File: rtl/hit_check.sv
// hit_check: combinational overlap test for one attacker against one defender.
// Ports:
//  gap        in  10  clamped distance between attacker front edge and defender
//  atk_state  in  4   attacker controller state
//  def_state  in  4   defender controller state
//  connected  in  1   attacker already landed this attack
//  connect    out 1   attack lands this cycle
//  block      out 1   attack lands and the defender is holding back
module hit_check
    import fight_pkg::*;
(
    input  logic [POS_W-1:0]   gap,
    input  logic [STATE_W-1:0] atk_state,
    input  logic [STATE_W-1:0] def_state,
    input  logic               connected,
    output logic               connect,
    output logic               block
);

    logic in_iattack;
    logic in_dattack;
    logic in_reach;

    // Reach depends on which active frame the attacker is in
    always_comb begin
        in_iattack = (atk_state == ST_IATTACK_ACTIVE);
        in_dattack = (atk_state == ST_DATTACK_ACTIVE);
        in_reach   = 1'b0;
        if (in_iattack) begin
            in_reach = (gap < POS_W'(I_REACH));
        end else if (in_dattack) begin
            in_reach = (gap < POS_W'(D_REACH));
        end
        connect = in_reach & ~connected;
        block   = connect & (def_state == ST_BACKWARD);
    end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: arbiter between the P1 and P2 gameplay controllers.
// Detects attack/hurtbox overlap each frame, pulses stunmode to the struck
// controller, keeps both health counters and runs the READY/FIGHT/KO round.
// Ports:
//  logic_clk     in  1   frame clock
//  reset         in  1   asynchronous, active-high
//  p1_pos_x      in  10  P1 left edge (faces right)
//  p2_pos_x      in  10  P2 left edge (faces left)
//  p1_state      in  4   P1 controller state
//  p2_state      in  4   P2 controller state
//  stunmode_p1   out 2   one-cycle 01 hit / 10 block pulse to P1
//  stunmode_p2   out 2   one-cycle 01 hit / 10 block pulse to P2
//  p1_health     out 4   P1 remaining health
//  p2_health     out 4   P2 remaining health
//  round_active  out 1   high only in FIGHT
//  winner        out 2   00 none, 01 P1, 10 P2, 11 draw
// Configuration macro: CHIP_DAMAGE_EN -- blocked hits cost CHIP_DAMAGE health.
module hit_resolver
    import fight_pkg::*;
(
    input  logic                logic_clk,
    input  logic                reset,
    input  logic [POS_W-1:0]    p1_pos_x,
    input  logic [POS_W-1:0]    p2_pos_x,
    input  logic [STATE_W-1:0]  p1_state,
    input  logic [STATE_W-1:0]  p2_state,
    output logic [STUN_W-1:0]   stunmode_p1,
    output logic [STUN_W-1:0]   stunmode_p2,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                round_active,
    output logic [WIN_W-1:0]    winner
);

`ifdef CHIP_DAMAGE_EN
    localparam int unsigned BLOCK_COST = CHIP_DAMAGE;
`else
    localparam int unsigned BLOCK_COST = 0;
`endif

    round_state_t           round_state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   p1_connected;
    logic                   p2_connected;

    logic [GAP_W-1:0]       gap_raw;
    logic [POS_W-1:0]       gap;
    logic                   detect;
    logic                   p1_connect_raw;
    logic                   p2_connect_raw;
    logic                   p2_blocks;
    logic                   p1_blocks;
    logic                   p1_strike;
    logic                   p2_strike;
    logic                   p1_active;
    logic                   p2_active;
    logic [HEALTH_W-1:0]    p1_damage;
    logic [HEALTH_W-1:0]    p2_damage;

    // Distance between P1's front edge and P2's left edge; overlap reads as 0
    always_comb begin
        gap_raw = GAP_W'({1'b0, p2_pos_x}) - GAP_W'({1'b0, p1_pos_x})
                - GAP_W'(PLAYER_WIDTH);
        gap     = gap_raw[GAP_W-1] ? '0 : gap_raw[POS_W-1:0];
    end

    hit_check u_p1_attack (
        .gap       (gap),
        .atk_state (p1_state),
        .def_state (p2_state),
        .connected (p1_connected),
        .connect   (p1_connect_raw),
        .block     (p2_blocks)
    );

    hit_check u_p2_attack (
        .gap       (gap),
        .atk_state (p2_state),
        .def_state (p1_state),
        .connected (p2_connected),
        .connect   (p2_connect_raw),
        .block     (p1_blocks)
    );

    // Detection only runs in FIGHT while nobody is already at zero health
    always_comb begin
        detect    = (round_state == RND_FIGHT) && (p1_health != '0) && (p2_health != '0);
        p1_strike = detect & p1_connect_raw;
        p2_strike = detect & p2_connect_raw;
        p1_active = (p1_state == ST_IATTACK_ACTIVE) || (p1_state == ST_DATTACK_ACTIVE);
        p2_active = (p2_state == ST_IATTACK_ACTIVE) || (p2_state == ST_DATTACK_ACTIVE);

        p2_damage = '0;
        if (p1_strike) begin
            p2_damage = p2_blocks ? HEALTH_W'(BLOCK_COST) : HEALTH_W'(HIT_DAMAGE);
        end
        p1_damage = '0;
        if (p2_strike) begin
            p1_damage = p1_blocks ? HEALTH_W'(BLOCK_COST) : HEALTH_W'(HIT_DAMAGE);
        end
    end

    // One hit per attack: flag holds while the attacker stays in an active frame
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            p1_connected <= 1'b0;
            p2_connected <= 1'b0;
        end else begin
            p1_connected <= p1_active & (p1_connected | p1_strike);
            p2_connected <= p2_active & (p2_connected | p2_strike);
        end
    end

    // Round FSM with registered stun pulses, health and result outputs
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            round_state  <= RND_READY;
            frame_cnt    <= '0;
            stunmode_p1  <= STUN_NONE;
            stunmode_p2  <= STUN_NONE;
            p1_health    <= HEALTH_W'(MAX_HEALTH);
            p2_health    <= HEALTH_W'(MAX_HEALTH);
            round_active <= 1'b0;
            winner       <= WIN_NONE;
        end else begin
            stunmode_p1 <= STUN_NONE;
            stunmode_p2 <= STUN_NONE;
            case (round_state)
                RND_READY: begin
                    if (frame_cnt == FRAME_CNT_W'(READY_FRAMES - 1)) begin
                        round_state  <= RND_FIGHT;
                        round_active <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    end
                end
                RND_FIGHT: begin
                    if ((p1_health == '0) || (p2_health == '0)) begin
                        round_state  <= RND_KO;
                        round_active <= 1'b0;
                        if ((p1_health == '0) && (p2_health == '0)) begin
                            winner <= WIN_DRAW;
                        end else if (p2_health == '0) begin
                            winner <= WIN_P1;
                        end else begin
                            winner <= WIN_P2;
                        end
                    end else begin
                        if (p1_strike) begin
                            stunmode_p2 <= p2_blocks ? STUN_BLOCK : STUN_HIT;
                        end
                        if (p2_strike) begin
                            stunmode_p1 <= p1_blocks ? STUN_BLOCK : STUN_HIT;
                        end
                        p1_health <= sat_sub(p1_health, p1_damage);
                        p2_health <= sat_sub(p2_health, p2_damage);
                    end
                end
                RND_KO: begin
                    round_active <= 1'b0;
                end
                default: begin
                    round_state  <= RND_READY;
                    round_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
